// File: rtl/prio_encoder_irq.sv
// prio_encoder_irq: clocked N-to-log2(N) priority encoder with sticky request
// capture and a valid/ack handshake. Requests accumulate in a pending register.
// One index is granted at a time and held until it is acknowledged.
// MODE 0 selects the highest pending index.
// MODE 1 selects round robin, starting just after the last acked index.
module prio_encoder_irq #(
  parameter int N    = 8,
  parameter int MODE = 0,
  localparam int W   = ($clog2(N) < 1) ? 1 : $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic         ack,
  output logic [W-1:0] out,
  output logic         valid,
  output logic [N-1:0] pending,
  output logic [W:0]   pend_cnt
);

  // Grant state is carried explicitly; valid mirrors it as its own flop.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [W-1:0] LAST_IDX = W'(N - 1);
  localparam logic [W-1:0] ZERO_IDX = {W{1'b0}};
  localparam logic [W-1:0] ONE_IDX  = {{(W-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Number of set bits in a pending vector.
  function automatic logic [W:0] popcount(input logic [N-1:0] v);
    logic [W:0] c;
    c = {(W+1){1'b0}};
    for (int i = 0; i < N; i++) begin
      c = c + {{W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // One-hot mask of an index. The mask is built by comparison, so an
  // out-of-range index can never address a bit outside the vector.
  function automatic logic [N-1:0] onehot(input logic [W-1:0] idx);
    logic [N-1:0] r;
    r = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      r[i] = (W'(i) == idx);
    end
    return r;
  endfunction

  // Highest set index. The ascending scan lets the last hit win.
  function automatic logic [W-1:0] sel_fixed(input logic [N-1:0] p);
    logic [W-1:0] s;
    s = ZERO_IDX;
    for (int i = 0; i < N; i++) begin
      if (p[i]) begin
        s = W'(i);
      end else begin
        s = s;
      end
    end
    return s;
  endfunction

  // First set index at or after start, scanning ascending and wrapping from
  // N-1 to 0. The index is reduced modulo N so it never reaches N or above.
  function automatic logic [W-1:0] sel_rr(input logic [N-1:0] p,
                                          input logic [W-1:0] start);
    logic [W-1:0] s;
    logic         found;
    int           k;
    s     = ZERO_IDX;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = int'(start) + i;
      if (k >= N) begin
        k = k - N;
      end else begin
        k = k;
      end
      if (p[k] && !found) begin
        s     = W'(k);
        found = 1'b1;
      end else begin
        s     = s;
        found = found;
      end
    end
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Registers and next-state signals
  // ---------------------------------------------------------------------------
  state_t       state_r;
  state_t       state_nxt_s;
  logic [W-1:0] out_r;
  logic [W-1:0] out_nxt_s;
  logic         valid_r;
  logic         valid_nxt_s;
  logic [N-1:0] pend_r;
  logic [W:0]   cnt_r;
  logic [W-1:0] ptr_r;
  logic [W-1:0] ptr_nxt_s;

  logic [N-1:0] reqm_s;
  logic [N-1:0] clr_s;
  logic [N-1:0] pnext_s;
  logic         take_s;
  logic [W-1:0] ptr_eff_s;
  logic [W-1:0] start_s;
  logic [W-1:0] sel_s;

  // Capture masking, ack clear, pending next value and the selected index.
  always_comb begin
    reqm_s    = {N{1'b0}};
    clr_s     = {N{1'b0}};
    take_s    = 1'b0;
    ptr_eff_s = ptr_r;
    start_s   = ZERO_IDX;
    sel_s     = ZERO_IDX;

    if (en) begin
      reqm_s = req;
    end else begin
      reqm_s = {N{1'b0}};
    end

    // An ack counts only while a grant is live.
    take_s = valid_r && ack;
    if (take_s) begin
      clr_s     = onehot(out_r);
      ptr_eff_s = out_r;
    end else begin
      clr_s     = {N{1'b0}};
      ptr_eff_s = ptr_r;
    end

    // Set wins: a request arriving on the bit being cleared keeps it pending.
    pnext_s = (pend_r & ~clr_s) | reqm_s;

    // On an ack edge, the search continues just after the grant being retired.
    if (ptr_eff_s == LAST_IDX) begin
      start_s = ZERO_IDX;
    end else begin
      start_s = ptr_eff_s + ONE_IDX;
    end

    if (MODE == 1) begin
      sel_s = sel_rr(pnext_s, start_s);
    end else begin
      sel_s = sel_fixed(pnext_s);
    end
  end

  // Grant FSM next-state and output decode.
  always_comb begin
    state_nxt_s = state_r;
    out_nxt_s   = out_r;
    valid_nxt_s = valid_r;
    ptr_nxt_s   = ptr_r;

    case (state_r)
      IDLE: begin
        if (|pnext_s) begin
          state_nxt_s = GRANT;
          out_nxt_s   = sel_s;
          valid_nxt_s = 1'b1;
        end else begin
          state_nxt_s = IDLE;
          out_nxt_s   = out_r;
          valid_nxt_s = 1'b0;
        end
      end
      GRANT: begin
        if (take_s) begin
          ptr_nxt_s = out_r;
          if (|pnext_s) begin
            // Back-to-back grant with no idle bubble.
            state_nxt_s = GRANT;
            out_nxt_s   = sel_s;
            valid_nxt_s = 1'b1;
          end else begin
            // Nothing left to serve, so out keeps its last value.
            state_nxt_s = IDLE;
            out_nxt_s   = out_r;
            valid_nxt_s = 1'b0;
          end
        end else begin
          // The grant is held, even against a higher-priority arrival.
          state_nxt_s = GRANT;
          out_nxt_s   = out_r;
          valid_nxt_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        out_nxt_s   = ZERO_IDX;
        valid_nxt_s = 1'b0;
        ptr_nxt_s   = LAST_IDX;
      end
    endcase
  end

  // State, grant, pending and count registers. Reset clears them asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      out_r   <= ZERO_IDX;
      valid_r <= 1'b0;
      pend_r  <= {N{1'b0}};
      cnt_r   <= {(W+1){1'b0}};
      ptr_r   <= LAST_IDX;
    end else begin
      state_r <= state_nxt_s;
      out_r   <= out_nxt_s;
      valid_r <= valid_nxt_s;
      pend_r  <= pnext_s;
      // Counting pnext here keeps pend_cnt equal to popcount(pending) every cycle.
      cnt_r   <= popcount(pnext_s);
      ptr_r   <= ptr_nxt_s;
    end
  end

  assign out      = out_r;
  assign valid    = valid_r;
  assign pending  = pend_r;
  assign pend_cnt = cnt_r;

endmodule

// File: tb/tb_prio_encoder_irq.sv
// Directed testbench for prio_encoder_irq. It uses three instances:
// N=8 fixed, N=8 round robin and N=5 round robin.
module tb_prio_encoder_irq;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic       ack;

  logic [2:0] out0;
  logic       valid0;
  logic [7:0] pending0;
  logic [3:0] cnt0;
  logic [2:0] out1;
  logic       valid1;
  logic [7:0] pending1;
  logic [3:0] cnt1;

  logic       rst5;
  logic       en5;
  logic [4:0] req5;
  logic       ack5;
  logic [2:0] out5;
  logic       valid5;
  logic [4:0] pending5;
  logic [3:0] cnt5;

  int checks;
  int errors;

  prio_encoder_irq #(.N(8), .MODE(0)) dut_fix (
    .clk(clk), .rst(rst), .en(en), .req(req), .ack(ack),
    .out(out0), .valid(valid0), .pending(pending0), .pend_cnt(cnt0)
  );

  prio_encoder_irq #(.N(8), .MODE(1)) dut_rr (
    .clk(clk), .rst(rst), .en(en), .req(req), .ack(ack),
    .out(out1), .valid(valid1), .pending(pending1), .pend_cnt(cnt1)
  );

  prio_encoder_irq #(.N(5), .MODE(1)) dut_rr5 (
    .clk(clk), .rst(rst5), .en(en5), .req(req5), .ack(ack5),
    .out(out5), .valid(valid5), .pending(pending5), .pend_cnt(cnt5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; req = 8'h00; ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (valid0 !== 1'b0 || out0 !== 3'd0 || pending0 !== 8'h00 || cnt0 !== 4'd0) begin errors++; $display("FAIL reset_fix got v=%b o=%0d p=%h c=%0d want 0 0 00 0", valid0, out0, pending0, cnt0); end
    checks++; if (valid1 !== 1'b0 || out1 !== 3'd0 || pending1 !== 8'h00 || cnt1 !== 4'd0) begin errors++; $display("FAIL reset_rr got v=%b o=%0d p=%h c=%0d want 0 0 00 0", valid1, out1, pending1, cnt1); end
    rst = 1'b0; en = 1'b0; req = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (valid0 !== 1'b0 || out0 !== 3'd0 || pending0 !== 8'h00 || cnt0 !== 4'd0) begin errors++; $display("FAIL en_gate cyc%0d got v=%b o=%0d p=%h c=%0d want 0 0 00 0", i, valid0, out0, pending0, cnt0); end
    end
    req = 8'h00;
  endtask

  task automatic test_onehot_sweep;
    logic [7:0] oh;
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      oh = 8'h01 << i;
      req = oh; ack = 1'b0;
      @(negedge clk);
      checks++; if (valid0 !== 1'b1 || out0 !== 3'(i) || pending0 !== oh) begin errors++; $display("FAIL sweep_grant i=%0d got v=%b o=%0d p=%h want 1 %0d %h", i, valid0, out0, pending0, i, oh); end
      req = 8'h00; ack = 1'b1;
      @(negedge clk);
      checks++; if (valid0 !== 1'b0 || pending0 !== 8'h00 || cnt0 !== 4'd0) begin errors++; $display("FAIL sweep_clear i=%0d got v=%b p=%h c=%0d want 0 00 0", i, valid0, pending0, cnt0); end
      ack = 1'b0;
    end
  endtask

  task automatic test_fixed_hold;
    req = 8'b0010_0100; ack = 1'b0;
    @(negedge clk);
    checks++; if (valid0 !== 1'b1 || out0 !== 3'd5 || cnt0 !== 4'd2) begin errors++; $display("FAIL fix_first got v=%b o=%0d c=%0d want 1 5 2", valid0, out0, cnt0); end
    req = 8'h80;
    @(negedge clk);
    checks++; if (out0 !== 3'd5 || pending0 !== 8'hA4 || cnt0 !== 4'd3) begin errors++; $display("FAIL fix_hold got o=%0d p=%h c=%0d want 5 a4 3", out0, pending0, cnt0); end
    req = 8'h00;
    @(negedge clk);
    checks++; if (valid0 !== 1'b1 || out0 !== 3'd5) begin errors++; $display("FAIL fix_hold2 got v=%b o=%0d want 1 5", valid0, out0); end
    ack = 1'b1;
    @(negedge clk);
    checks++; if (valid0 !== 1'b1 || out0 !== 3'd7 || cnt0 !== 4'd2) begin errors++; $display("FAIL fix_b2b7 got v=%b o=%0d c=%0d want 1 7 2", valid0, out0, cnt0); end
    @(negedge clk);
    checks++; if (valid0 !== 1'b1 || out0 !== 3'd2 || cnt0 !== 4'd1) begin errors++; $display("FAIL fix_b2b2 got v=%b o=%0d c=%0d want 1 2 1", valid0, out0, cnt0); end
    @(negedge clk);
    checks++; if (valid0 !== 1'b0 || out0 !== 3'd2 || cnt0 !== 4'd0) begin errors++; $display("FAIL fix_drain got v=%b o=%0d c=%0d want 0 2 0", valid0, out0, cnt0); end
    ack = 1'b0;
  endtask

  task automatic test_round_robin;
    rst = 1'b1; req = 8'h00; ack = 1'b0;
    @(negedge clk);
    rst = 1'b0; en = 1'b1; req = 8'hFF;
    @(negedge clk);
    checks++; if (valid1 !== 1'b1 || out1 !== 3'd0 || pending1 !== 8'hFF || cnt1 !== 4'd8) begin errors++; $display("FAIL rr_first got v=%b o=%0d p=%h c=%0d want 1 0 ff 8", valid1, out1, pending1, cnt1); end
    req = 8'h00; ack = 1'b1;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      checks++; if (valid1 !== 1'b1 || out1 !== 3'(i) || cnt1 !== 4'(8 - i)) begin errors++; $display("FAIL rr_seq i=%0d got v=%b o=%0d c=%0d want 1 %0d %0d", i, valid1, out1, cnt1, i, 8 - i); end
    end
    @(negedge clk);
    checks++; if (valid1 !== 1'b0 || cnt1 !== 4'd0) begin errors++; $display("FAIL rr_drain got v=%b c=%0d want 0 0", valid1, cnt1); end
    ack = 1'b0; req = 8'h81;
    @(negedge clk);
    checks++; if (valid1 !== 1'b1 || out1 !== 3'd0) begin errors++; $display("FAIL rr_wrap0 got v=%b o=%0d want 1 0", valid1, out1); end
    req = 8'h00; ack = 1'b1;
    @(negedge clk);
    checks++; if (valid1 !== 1'b1 || out1 !== 3'd7 || cnt1 !== 4'd1) begin errors++; $display("FAIL rr_wrap7 got v=%b o=%0d c=%0d want 1 7 1", valid1, out1, cnt1); end
    @(negedge clk);
    checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL rr_wrap_end got v=%b want 0", valid1); end
    ack = 1'b0;
  endtask

  task automatic test_set_wins;
    rst = 1'b1; req = 8'h00; ack = 1'b0;
    @(negedge clk);
    rst = 1'b0; en = 1'b1; req = 8'h08;
    @(negedge clk);
    checks++; if (valid0 !== 1'b1 || out0 !== 3'd3) begin errors++; $display("FAIL setwin_pre got v=%b o=%0d want 1 3", valid0, out0); end
    req = 8'h08; ack = 1'b1;
    @(negedge clk);
    checks++; if (pending0 !== 8'h08 || valid0 !== 1'b1 || out0 !== 3'd3) begin errors++; $display("FAIL setwin_regrant got p=%h v=%b o=%0d want 08 1 3", pending0, valid0, out0); end
    req = 8'h00;
    @(negedge clk);
    checks++; if (valid0 !== 1'b0 || pending0 !== 8'h00) begin errors++; $display("FAIL setwin_clear got v=%b p=%h want 0 00", valid0, pending0); end
    ack = 1'b0;
  endtask

  task automatic test_async_reset;
    logic [2:0] exp_seq [4];
    exp_seq[0] = 3'd2; exp_seq[1] = 3'd3; exp_seq[2] = 3'd4; exp_seq[3] = 3'd0;
    rst5 = 1'b1; en5 = 1'b1; req5 = 5'b00000; ack5 = 1'b0;
    @(negedge clk);
    rst5 = 1'b0; req5 = 5'b01000;
    @(negedge clk);
    checks++; if (valid5 !== 1'b1 || out5 !== 3'd3) begin errors++; $display("FAIL n5_setup got v=%b o=%0d want 1 3", valid5, out5); end
    req5 = 5'b00000; ack5 = 1'b1;
    @(negedge clk);
    ack5 = 1'b0; req5 = 5'b10110;
    @(negedge clk);
    checks++; if (valid5 !== 1'b1 || out5 !== 3'd4 || pending5 !== 5'b10110 || cnt5 !== 4'd3) begin errors++; $display("FAIL n5_grant4 got v=%b o=%0d p=%b c=%0d want 1 4 10110 3", valid5, out5, pending5, cnt5); end
    req5 = 5'b00000;
    #2 rst5 = 1'b1;
    #1;
    checks++; if (valid5 !== 1'b0 || out5 !== 3'd0 || pending5 !== 5'b00000 || cnt5 !== 4'd0) begin errors++; $display("FAIL n5_async got v=%b o=%0d p=%b c=%0d want 0 0 00000 0", valid5, out5, pending5, cnt5); end
    @(negedge clk);
    rst5 = 1'b0; req5 = 5'b00001;
    @(negedge clk);
    checks++; if (valid5 !== 1'b1 || out5 !== 3'd0 || pending5 !== 5'b00001 || cnt5 !== 4'd1) begin errors++; $display("FAIL n5_after got v=%b o=%0d p=%b c=%0d want 1 0 00001 1", valid5, out5, pending5, cnt5); end
    req5 = 5'b11111; ack5 = 1'b1;
    @(negedge clk);
    checks++; if (valid5 !== 1'b1 || out5 !== 3'd1 || cnt5 !== 4'd5) begin errors++; $display("FAIL n5_refill got v=%b o=%0d c=%0d want 1 1 5", valid5, out5, cnt5); end
    req5 = 5'b00000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (valid5 !== 1'b1 || out5 !== exp_seq[i] || cnt5 !== 4'(4 - i)) begin errors++; $display("FAIL n5_seq i=%0d got v=%b o=%0d c=%0d want 1 %0d %0d", i, valid5, out5, cnt5, exp_seq[i], 4 - i); end
      checks++; if (out5 > 3'd4) begin errors++; $display("FAIL n5_range i=%0d got o=%0d want <=4", i, out5); end
    end
    @(negedge clk);
    checks++; if (valid5 !== 1'b0 || cnt5 !== 4'd0) begin errors++; $display("FAIL n5_drain got v=%b c=%0d want 0 0", valid5, cnt5); end
    ack5 = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; en = 1'b0; req = 8'h00; ack = 1'b0;
    rst5 = 1'b1; en5 = 1'b0; req5 = 5'b00000; ack5 = 1'b0;
    test_reset();
    test_onehot_sweep();
    test_fixed_hold();
    test_round_robin();
    test_set_wins();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prio_encoder_irq.md
# prio_encoder_irq

Parametrised, registered N-to-log2(N) priority encoder with sticky request capture and a valid/ack handshake. Requests are latched into a pending register, and the block presents one granted index at a time. The index is held until the consumer acknowledges it, and that pending bit is then cleared. The block generalises the team's combinational 8-to-3 encoder with enable into a clocked interrupt-style encoder for the event and interrupt paths. It supports fixed-priority and round-robin selection.

## Interface
- N, default 8: number of request lines; legal for N >= 2, including non-powers of two.
- MODE, default 0: selection mode. 0 is fixed priority, where the highest index wins. 1 is round robin.
- W (localparam), default clog2(N): index width, with a minimum of 1.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous and active-high.
- en  input  1  request capture enable. When 0, req is ignored; already-pending bits are still served.
- req  input  N  request lines, sampled each rising edge when en=1, one bit per source.
- ack  input  1  consumer accepts the current grant. Only meaningful when valid=1.
- out  output  W  granted index, registered.
- valid  output  1  out holds a live grant, registered.
- pending  output  N  pending register contents, registered.
- pend_cnt  output  W+1  popcount of the pending output.

## Operation
- Effective requests: reqm = en ? req : 0.
- Clear mask: clr = (valid && ack) ? onehot(out) : 0.
- Pending update at every edge: pending <= (pending & ~clr) | reqm.
  - Set wins: a new req on the bit being acked leaves that bit set, so the source is served again later.
- Two states, implied by valid:
  - IDLE (valid=0). At each edge: out <= select(pnext) and valid <= |pnext, where pnext is the pending value written at that edge.
  - GRANT (valid=1).
    - With ack=0: out and valid are held, even if a higher-priority request arrives.
    - With ack=1: same update as IDLE, giving back-to-back grants with no bubble. If pnext is 0, the block returns to IDLE and out is held at its last value.
- MODE 0: select returns the highest set index of pnext.
- MODE 1 (round robin):
  - An internal pointer ptr (W bits, range 0..N-1) records the index of the last acked grant. It updates to out on each valid&&ack.
  - select searches pnext ascending from (ptr+1) mod N, wrapping at N-1 to 0. The first set bit wins.
  - Indices at or above N are never produced.
- ack with valid=0 is ignored: no clear and no pointer update.
- pend_cnt is the popcount of the pending register output.

## Timing
- Reset values, applied immediately on rst asserting and independent of clk:
  - pending=0, out=0, valid=0, pend_cnt=0.
  - ptr=N-1, so the first round-robin search starts at index 0.
- Latency: a req bit high at rising edge t, with en=1 and the block idle, gives valid=1 and out=index after edge t. That is 1 cycle with no combinational input-to-output path.
- Ack to next grant: ack high at edge t updates out and valid at edge t. The next grant is visible in the cycle following t.
- Throughput: one grant per cycle when ack is held high continuously.
- The pending output reflects captures and clears one cycle after the sampling edge.
- Reset asserted mid-grant discards all pending requests and the grant. Requests must be re-presented after rst deasserts. The first capture is at the first rising edge with rst low.

## Test plan
- Reset and enable gating:
  - Stimulus: rst pulse, then en=0 with req=8'hFF for 3 cycles.
  - Required: valid=0, out=0, pending=0, pend_cnt=0 throughout.
- One-hot sweep, N=8, MODE=0:
  - Stimulus: en=1; for i=0..7, drive req=2**i for 1 cycle, then ack once valid is seen.
  - Required: out=i with valid=1 one cycle after each req; pending returns to 0 after each ack.
- Fixed priority and hold:
  - Stimulus: req=8'b0010_0100 for 1 cycle, then req=8'h80 for 1 cycle with ack=0.
  - Required: out=5 and stays 5 while ack=0.
  - Then ack=1 held: out=7, then out=2, then valid=0, with pend_cnt going 3, 2, 1, 0.
- Round robin, MODE=1:
  - Stimulus: pending=8'hFF is set by a 1-cycle req, then ack is held high.
  - Required: out sequence 0,1,2,...,7 on consecutive cycles, then valid=0.
  - A second burst of req=8'h81 after the last ack (ptr=7) grants 0, then 7.
- Set-wins collision:
  - Stimulus: while out=3 and valid=1, assert ack=1 and req=8'h08 in the same cycle.
  - Required: pending[3] stays 1, and index 3 is granted again (immediately if it is the only pending bit).
- Async reset mid-operation, N=5, MODE=1:
  - Stimulus: pending=5'b10110, out=4 and valid=1; assert rst between clock edges.
  - Required: all outputs go to reset values immediately, without waiting for a clock edge.
  - After release, req=5'b00001 gives out=0 one cycle later, and out never reaches 5..7.
